// File: rtl/bus_str_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_str_mux : round-robin CHN-channel bus to beat-stream packer   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bus_str_mux #(
  parameter int CHN   = 2,
  parameter int ADR_B = 4,
  parameter int DAT_B = 4,
  parameter int STR_B = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [CHN-1:0]                        bus_vld,
  input  logic [CHN*ADR_B*8-1:0]                bus_adr,
  input  logic [CHN*DAT_B*8-1:0]                bus_dat,
  output logic [CHN-1:0]                        bus_rdy,
  output logic                                  str_vld,
  output logic [STR_B*8-1:0]                    str_dat,
  output logic [((CHN > 1) ? $clog2(CHN) : 1)-1:0] str_chn,
  output logic                                  str_lst,
  input  logic                                  str_rdy
);

  localparam int PKT_B = ADR_B + DAT_B;
  localparam int BEATS = PKT_B / STR_B;
  localparam int ADR_W = ADR_B * 8;
  localparam int DAT_W = DAT_B * 8;
  localparam int PKT_W = PKT_B * 8;
  localparam int STR_W = STR_B * 8;
  localparam int CW    = (CHN > 1) ? $clog2(CHN) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] C_LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] C_LAST_CHN  = CW'(CHN - 1);

  generate
    if ((PKT_B % STR_B) != 0) begin : g_bad_beat
      $error("bus_str_mux: packet of %0d bytes is not a multiple of %0d-byte beats", PKT_B, STR_B);
    end
    if ((CHN < 1) || (CHN > 16)) begin : g_bad_chn
      $error("bus_str_mux: CHN=%0d outside 1..16", CHN);
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    last_q, last_d;
  logic [CW-1:0]    chn_q, chn_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [CW-1:0]    grant, cand;
  logic             grant_vld;
  logic             last_beat, beat_acc, bus_acc;
  logic [PKT_W-1:0] chn_pkt [CHN];

  generate
    for (genvar g = 0; g < CHN; g++) begin : g_chn
      assign chn_pkt[g] = {bus_adr[g*ADR_W +: ADR_W], bus_dat[g*DAT_W +: DAT_W]};
      assign bus_rdy[g] = rst_n & bus_acc & (grant == CW'(g));
    end
  endgenerate

  // Scan from the farthest candidate back to last_q+1 so the nearest valid one wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = CHN; i >= 1; i--) begin
      cand = CW'((int'(last_q) + i) % CHN);
      if (bus_vld[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
  end

  assign last_beat = (cnt_q == C_LAST_BEAT);
  assign beat_acc  = (state_q == SEND) && str_rdy;
  assign bus_acc   = grant_vld && ((state_q == IDLE) || (last_beat && beat_acc));

  // The packet register shifts left per beat, so the stream payload is always its top slice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    chn_d   = chn_q;
    pkt_d   = pkt_q;
    if (bus_acc) begin
      state_d = SEND;
      cnt_d   = '0;
      last_d  = grant;
      chn_d   = grant;
      pkt_d   = chn_pkt[grant];
    end else if (beat_acc) begin
      if (last_beat) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        pkt_d = pkt_q << STR_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= C_LAST_CHN;
      chn_q   <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      chn_q   <= chn_d;
      pkt_q   <= pkt_d;
    end
  end

  assign str_vld = (state_q == SEND);
  assign str_dat = pkt_q[PKT_W-1 -: STR_W];
  assign str_chn = chn_q;
  assign str_lst = (state_q == SEND) && last_beat;

endmodule
`default_nettype wire

// File: tb/tb_bus_str_mux.sv
`default_nettype none
// tb_bus_str_mux : directed and randomised checks of bus_str_mux against a beat-queue model.
module tb_bus_str_mux;

  localparam int CHN = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  bus_vld;
  logic [63:0] bus_adr;
  logic [63:0] bus_dat;
  logic        str_rdy;

  logic [1:0]  bus_rdy;
  logic        str_vld;
  logic [15:0] str_dat;
  logic [0:0]  str_chn;
  logic        str_lst;

  logic [1:0]  bus_rdy8;
  logic        str_vld8;
  logic [63:0] str_dat8;
  logic [0:0]  str_chn8;
  logic        str_lst8;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] dat;
    logic        lst;
    logic        chn;
  } beat_t;

  beat_t mq[$];
  int    m_last;

  logic [15:0] exp_b [4] = '{16'h1122, 16'h3344, 16'hAABB, 16'hCCDD};

  always #5 clk = ~clk;

  bus_str_mux #(.CHN(2), .ADR_B(4), .DAT_B(4), .STR_B(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus_vld(bus_vld), .bus_adr(bus_adr), .bus_dat(bus_dat),
    .bus_rdy(bus_rdy), .str_vld(str_vld), .str_dat(str_dat), .str_chn(str_chn),
    .str_lst(str_lst), .str_rdy(str_rdy)
  );

  bus_str_mux #(.CHN(2), .ADR_B(4), .DAT_B(4), .STR_B(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus_vld(bus_vld), .bus_adr(bus_adr), .bus_dat(bus_dat),
    .bus_rdy(bus_rdy8), .str_vld(str_vld8), .str_dat(str_dat8), .str_chn(str_chn8),
    .str_lst(str_lst8), .str_rdy(str_rdy)
  );

  task automatic set_ch(input int c, input logic [31:0] a, input logic [31:0] d);
    bus_adr[c*32 +: 32] = a;
    bus_dat[c*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus_vld = '0;
    str_rdy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mq.delete();
    m_last = CHN - 1;
  endtask

  // A new packet may enter only when nothing is pending or the sole pending beat leaves now.
  function automatic int exp_grant();
    if (!(mq.size() == 0 || (mq.size() == 1 && str_rdy))) return -1;
    for (int i = 1; i <= CHN; i++)
      if (bus_vld[(m_last + i) % CHN]) return (m_last + i) % CHN;
    return -1;
  endfunction

  task automatic model_edge();
    int g;
    logic [63:0] pkt;
    g = exp_grant();
    if (str_rdy && mq.size() != 0) void'(mq.pop_front());
    if (g >= 0) begin
      pkt = {bus_adr[g*32 +: 32], bus_dat[g*32 +: 32]};
      for (int k = 0; k < 4; k++)
        mq.push_back('{dat: 16'(pkt >> (16 * (3 - k))), lst: (k == 3), chn: 1'(g)});
      m_last = g;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus_vld = 2'b11;
    str_rdy = 1'b1;
    set_ch(0, $urandom, $urandom);
    set_ch(1, $urandom, $urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk += 10;
    if (str_vld !== 1'b0)   begin n_fail++; $display("FAIL rst_vld: got %b want 0", str_vld); end
    if (str_lst !== 1'b0)   begin n_fail++; $display("FAIL rst_lst: got %b want 0", str_lst); end
    if (str_dat !== 16'h0)  begin n_fail++; $display("FAIL rst_dat: got %h want 0", str_dat); end
    if (str_chn !== 1'b0)   begin n_fail++; $display("FAIL rst_chn: got %b want 0", str_chn); end
    if (bus_rdy !== 2'b00)  begin n_fail++; $display("FAIL rst_rdy: got %b want 00", bus_rdy); end
    if (str_vld8 !== 1'b0)  begin n_fail++; $display("FAIL rst8_vld: got %b want 0", str_vld8); end
    if (str_lst8 !== 1'b0)  begin n_fail++; $display("FAIL rst8_lst: got %b want 0", str_lst8); end
    if (str_dat8 !== 64'h0) begin n_fail++; $display("FAIL rst8_dat: got %h want 0", str_dat8); end
    if (str_chn8 !== 1'b0)  begin n_fail++; $display("FAIL rst8_chn: got %b want 0", str_chn8); end
    if (bus_rdy8 !== 2'b00) begin n_fail++; $display("FAIL rst8_rdy: got %b want 00", bus_rdy8); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk += 2;
    if (bus_rdy !== 2'b01)  begin n_fail++; $display("FAIL rst_prio: got %b want 01", bus_rdy); end
    if (bus_rdy8 !== 2'b01) begin n_fail++; $display("FAIL rst8_prio: got %b want 01", bus_rdy8); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic exp_v;
    do_reset();
    set_ch(0, 32'h11223344, 32'hAABBCCDD);
    str_rdy = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      bus_vld = (cyc == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
      exp_v = (cyc >= 1 && cyc <= 4);
      n_chk += 2;
      if (bus_rdy !== ((cyc == 0) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL single_rdy cyc %0d: got %b want %b", cyc, bus_rdy, (cyc == 0) ? 2'b01 : 2'b00);
      end
      if (str_vld !== exp_v) begin
        n_fail++; $display("FAIL single_vld cyc %0d: got %b want %b", cyc, str_vld, exp_v);
      end
      if (exp_v) begin
        n_chk += 3;
        if (str_dat !== exp_b[cyc-1]) begin
          n_fail++; $display("FAIL single_dat cyc %0d: got %h want %h", cyc, str_dat, exp_b[cyc-1]);
        end
        if (str_lst !== (cyc == 4)) begin
          n_fail++; $display("FAIL single_lst cyc %0d: got %b want %b", cyc, str_lst, cyc == 4);
        end
        if (str_chn !== 1'b0) begin
          n_fail++; $display("FAIL single_chn cyc %0d: got %b want 0", cyc, str_chn);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fairness();
    int g;
    logic [1:0] exp_rdy;
    int chs[$];
    do_reset();
    set_ch(0, $urandom, $urandom);
    set_ch(1, $urandom, $urandom);
    bus_vld = 2'b11;
    str_rdy = 1'b1;
    for (int cyc = 0; cyc < 17; cyc++) begin
      @(negedge clk);
      g = exp_grant();
      exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
      n_chk++;
      if (bus_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL fair_rdy cyc %0d: got %b want %b", cyc, bus_rdy, exp_rdy);
      end
      if (cyc >= 1) begin
        n_chk++;
        if (str_vld !== 1'b1) begin n_fail++; $display("FAIL fair_bubble cyc %0d: got %b want 1", cyc, str_vld); end
      end
      if (mq.size() != 0) begin
        n_chk++;
        if ({str_dat, str_lst, str_chn} !== mq[0]) begin
          n_fail++; $display("FAIL fair_beat cyc %0d: got dat=%h lst=%b chn=%b want dat=%h lst=%b chn=%b",
                             cyc, str_dat, str_lst, str_chn, mq[0].dat, mq[0].lst, mq[0].chn);
        end
      end
      if (str_vld === 1'b1 && str_lst === 1'b1) chs.push_back(int'(str_chn));
      model_edge();
    end
    n_chk++;
    if (chs.size() != 4) begin
      n_fail++; $display("FAIL fair_count: got %0d packets want 4", chs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (chs[k] != k % 2) begin n_fail++; $display("FAIL fair_order pkt %0d: got ch%0d want ch%0d", k, chs[k], k % 2); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    do_reset();
    set_ch(0, 32'h11223344, 32'hAABBCCDD);
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus_vld = (cyc == 0) ? 2'b01 : 2'b00;
      str_rdy = !(cyc >= 2 && cyc <= 4);
      @(negedge clk);
      if (cyc >= 2 && cyc <= 5) begin
        n_chk++;
        if (str_vld !== 1'b1 || str_dat !== 16'h3344) begin
          n_fail++; $display("FAIL bp_hold cyc %0d: got vld=%b dat=%h want vld=1 dat=3344", cyc, str_vld, str_dat);
        end
      end
      if (str_vld === 1'b1 && str_rdy) got.push_back(str_dat);
      @(posedge clk); #1;
    end
    n_chk++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d beats want 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (got[k] !== exp_b[k]) begin n_fail++; $display("FAIL bp_beat %0d: got %h want %h", k, got[k], exp_b[k]); end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_ch(0, 32'h11223344, 32'hAABBCCDD);
    bus_vld = 2'b01;
    str_rdy = 1'b1;
    @(negedge clk); model_edge();
    bus_vld = 2'b00;
    @(negedge clk); model_edge();
    @(negedge clk);
    n_chk++;
    if (str_dat !== 16'h3344) begin n_fail++; $display("FAIL mrst_beat1: got %h want 3344", str_dat); end
    model_edge();
    rst_n = 1'b0;
    #1;
    n_chk += 2;
    if (str_vld !== 1'b0)  begin n_fail++; $display("FAIL mrst_vld: got %b want 0", str_vld); end
    if (bus_rdy !== 2'b00) begin n_fail++; $display("FAIL mrst_rdy: got %b want 00", bus_rdy); end
    mq.delete();
    m_last = CHN - 1;
    @(posedge clk); #1;
    set_ch(1, $urandom, $urandom);
    bus_vld = 2'b10;
    rst_n   = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus_rdy !== 2'b10) begin n_fail++; $display("FAIL mrst_ch1: got %b want 10", bus_rdy); end
    model_edge();
    bus_vld = 2'b00;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      n_chk++;
      if (str_vld !== (mq.size() != 0)) begin
        n_fail++; $display("FAIL mrst_vld_after cyc %0d: got %b want %b", cyc, str_vld, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        n_chk++;
        if ({str_dat, str_lst, str_chn} !== mq[0]) begin
          n_fail++; $display("FAIL mrst_beat cyc %0d: got dat=%h lst=%b chn=%b want dat=%h lst=%b chn=%b",
                             cyc, str_dat, str_lst, str_chn, mq[0].dat, mq[0].lst, mq[0].chn);
        end
      end
      model_edge();
    end
  endtask

  task automatic test_str8();
    logic [63:0] prev_pkt;
    logic        prev_chn;
    logic [1:0]  exp_rdy;
    do_reset();
    bus_vld  = 2'b11;
    str_rdy  = 1'b1;
    prev_pkt = '0;
    prev_chn = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      set_ch(0, $urandom, $urandom);
      set_ch(1, $urandom, $urandom);
      @(negedge clk);
      exp_rdy = (cyc % 2 == 0) ? 2'b01 : 2'b10;
      n_chk++;
      if (bus_rdy8 !== exp_rdy) begin n_fail++; $display("FAIL s8_rdy cyc %0d: got %b want %b", cyc, bus_rdy8, exp_rdy); end
      if (cyc > 0) begin
        n_chk += 4;
        if (str_vld8 !== 1'b1)    begin n_fail++; $display("FAIL s8_vld cyc %0d: got %b want 1", cyc, str_vld8); end
        if (str_lst8 !== 1'b1)    begin n_fail++; $display("FAIL s8_lst cyc %0d: got %b want 1", cyc, str_lst8); end
        if (str_chn8 !== prev_chn) begin n_fail++; $display("FAIL s8_chn cyc %0d: got %b want %b", cyc, str_chn8, prev_chn); end
        if (str_dat8 !== prev_pkt) begin n_fail++; $display("FAIL s8_dat cyc %0d: got %h want %h", cyc, str_dat8, prev_pkt); end
      end
      prev_chn = 1'(cyc % 2);
      prev_pkt = {bus_adr[(cyc % 2)*32 +: 32], bus_dat[(cyc % 2)*32 +: 32]};
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int g;
    logic [1:0] exp_rdy;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus_vld = 2'($urandom_range(0, 3));
      str_rdy = ($urandom_range(0, 3) != 0);
      set_ch(0, $urandom, $urandom);
      set_ch(1, $urandom, $urandom);
      @(negedge clk);
      g = exp_grant();
      exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
      n_chk += 2;
      if (bus_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL rnd_rdy cyc %0d: got %b want %b", cyc, bus_rdy, exp_rdy);
      end
      if (str_vld !== (mq.size() != 0)) begin
        n_fail++; $display("FAIL rnd_vld cyc %0d: got %b want %b", cyc, str_vld, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        n_chk++;
        if ({str_dat, str_lst, str_chn} !== mq[0]) begin
          n_fail++; $display("FAIL rnd_beat cyc %0d: got dat=%h lst=%b chn=%b want dat=%h lst=%b chn=%b",
                             cyc, str_dat, str_lst, str_chn, mq[0].dat, mq[0].lst, mq[0].chn);
        end
      end
      model_edge();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    bus_vld = '0;
    bus_adr = '0;
    bus_dat = '0;
    str_rdy = 1'b0;
    m_last  = CHN - 1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_mid_reset();
    test_str8();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_str_mux.md
BUS_STR_MUX -- requirements
Module: bus_str_mux

Interface
REQ-001 The block SHALL have parameter CHN, default 2, meaning the number of bus input channels (1..16).
REQ-002 The block SHALL have parameter ADR_B, default 4, meaning the address width in bytes.
REQ-003 The block SHALL have parameter DAT_B, default 4, meaning the data width in bytes.
REQ-004 The block SHALL have parameter STR_B, default 2, meaning the stream beat width in bytes; PKT_B = ADR_B+DAT_B and BEATS = PKT_B/STR_B.
REQ-005 The block SHALL stop elaboration with an error if PKT_B is not a multiple of STR_B.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port bus_vld, input, CHN bits: per-channel bus request valid.
REQ-009 The block SHALL have port bus_adr, input, CHN*ADR_B*8 bits: per-channel address, with channel c at slice c.
REQ-010 The block SHALL have port bus_dat, input, CHN*DAT_B*8 bits: per-channel data, with channel c at slice c.
REQ-011 The block SHALL have port bus_rdy, output, CHN bits: per-channel accept.
REQ-012 The block SHALL have port str_vld, output, 1 bit: stream beat valid.
REQ-013 The block SHALL have port str_dat, output, STR_B*8 bits: stream beat payload.
REQ-014 The block SHALL have port str_chn, output, max(1,$clog2(CHN)) bits: source channel of the current packet.
REQ-015 The block SHALL have port str_lst, output, 1 bit: marks the last beat of a packet.
REQ-016 The block SHALL have port str_rdy, input, 1 bit: stream sink ready.

Function
REQ-017 The block SHALL transfer a bus request when bus_vld[c] and bus_rdy[c] are both 1 on a rising clk edge, and a stream beat when str_vld and str_rdy are both 1.
REQ-018 The block SHALL assert at most one bus_rdy bit per cycle, and only for a channel whose bus_vld is 1.
REQ-019 The block SHALL grant channels round-robin: the search starts at last_grant+1 modulo CHN, and last_grant updates only on an accepted transfer.
REQ-020 The block SHALL form the packet {adr,dat} on acceptance, with address most significant, and register it together with the channel index.
REQ-021 The block SHALL emit beat k (0..BEATS-1) as packet bytes PKT_B-1-k*STR_B down to PKT_B-(k+1)*STR_B, MSB first.
REQ-022 The block SHALL use a two-state FSM: IDLE goes to SEND on acceptance; SEND goes to IDLE when the last beat is accepted and no new request is accepted in that cycle; SEND stays in SEND when the last beat is accepted and a new request is accepted in that cycle.
REQ-023 The block SHALL set bus_rdy[g] = grant==g AND (state==IDLE OR (last beat AND str_rdy)), allowing back-to-back packets with zero idle cycles.
REQ-024 The block SHALL hold str_vld=1 in SEND, drive str_vld=0 in IDLE, and drive str_lst=1 only when the beat counter equals BEATS-1.
REQ-025 The block SHALL keep str_dat, str_chn and str_lst stable while str_vld=1 and str_rdy=0, without dropping or duplicating any beat.
REQ-026 The block SHALL increment the beat counter on each accepted beat and clear it on the accepted last beat.
REQ-027 The block SHALL emit every packet with str_lst=1 on its only beat when BEATS=1, sustaining one packet per cycle.
REQ-028 The block SHALL re-arbitrate every cycle, so a channel may drop bus_vld before being granted without side effects.
REQ-029 The block SHALL present the first accepted beat at latency 1 cycle after bus acceptance.

Reset
REQ-030 The block SHALL, while rst_n=0, force state=IDLE, beat counter=0, last_grant=CHN-1 (so channel 0 has first priority), packet register=0, str_vld=0, str_lst=0, str_dat=0, str_chn=0 and bus_rdy=0.
REQ-031 The block SHALL, when reset is asserted mid-packet, discard the partial packet and emit none of its remaining beats after release.

Verification
REQ-032 The bench SHALL cover single transfer (defaults): ch0 adr=0x11223344, dat=0xAABBCCDD, str_rdy=1 -> beats 0x1122, 0x3344, 0xAABB, 0xCCDD; str_chn=0; str_lst only on the 4th beat; bus_rdy[0] high for 1 cycle.
REQ-033 The bench SHALL cover fairness: both channels continuously valid, str_rdy=1 -> packets from channels 0,1,0,1, with str_vld continuously 1 (no bubbles).
REQ-034 The bench SHALL cover backpressure: str_rdy=0 for 3 cycles during beat 2 -> str_dat=0x3344 held, and all 4 beats delivered exactly once.
REQ-035 The bench SHALL cover reset mid-packet: rst_n low after beat 1 -> str_vld=0 immediately; after release, ch1 request is granted first only if ch0 is idle; no residual beats appear.
REQ-036 The bench SHALL cover STR_B=8: alternating ch0/ch1 -> one packet per cycle with str_lst=1 on every beat.
REQ-037 The bench SHALL cover illegal parameters: STR_B=3 with defaults -> elaboration error.
